// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: parity modes, FSM state
// types and small helpers used by both the TX and RX paths.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Total bits on the wire for one frame, start bit included.
  function automatic int frame_bits(input int data_bits, input int parity,
                                    input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Parity bit for a zero-extended data word; unused upper bits are zero and
  // do not disturb the reduction.
  function automatic logic parity_bit(input logic [7:0] data, input int parity);
    return (parity == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX front end: 2-flop synchroniser, oversampling tick timing and the RX
// frame FSM. Emits a one-cycle done strobe at the final stop-bit sample
// together with the assembled frame and its error status.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIVISOR    = 651
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 done,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_err,
  output logic                 frame_err,
  output rx_state_t            state
);

  localparam int DIV_W  = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIVISOR - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  logic [1:0]           sync;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [TICK_W-1:0]    tick_cnt;
  logic [2:0]           data_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 perr;
  logic                 ferr;
  logic                 tick_pulse;
  logic                 sample_now;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end

  assign rx_s       = sync[1];
  assign tick_pulse = (div_cnt == DIV_LAST);
  // The start bit is sampled half a bit in; every later bit a full bit on.
  assign sample_now = tick_pulse &&
                      (tick_cnt == ((state == RX_START) ? HALF_LAST : TICK_LAST));
  assign done       = (state == RX_STOP) && sample_now && (stop_idx == STOP_LAST);
  assign data       = shift;
  assign parity_err = perr;
  // Folds in the stop sample being taken this cycle; only meaningful with done.
  assign frame_err  = ferr | ~rx_s;

  // RX frame FSM with its divisor and tick counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RX_IDLE;
      div_cnt  <= '0;
      tick_cnt <= '0;
      data_idx <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (state != RX_IDLE) begin
        if (tick_pulse) begin
          div_cnt  <= '0;
          tick_cnt <= sample_now ? '0 : tick_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state    <= RX_START;
            div_cnt  <= '0;
            tick_cnt <= '0;
            data_idx <= '0;
            stop_idx <= 1'b0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
          end
        end
        RX_START: begin
          // A high mid-bit sample means the falling edge was a glitch.
          if (sample_now) state <= rx_s ? RX_IDLE : RX_DATA;
        end
        RX_DATA: begin
          if (sample_now) begin
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (data_idx == DATA_LAST)
              state <= (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            else
              data_idx <= data_idx + 1'b1;
          end
        end
        RX_PARITY: begin
          if (sample_now) begin
            perr  <= (rx_s != parity_bit(8'(shift), PARITY));
            state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (sample_now) begin
            if (!rx_s) ferr <= 1'b1;
            if (stop_idx == STOP_LAST) state <= RX_IDLE;
            else                       stop_idx <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART. TX path is an inline FSM with registered
// outputs; RX timing lives in uart_rx_sampler and this level holds the
// received word with valid/ready and error/overrun reporting.
//
// Handshakes: a transfer occurs on a rising clock edge where valid && ready
// are both high; the producer holds data stable while valid is high and not
// yet accepted, and ready may be high before valid.
module uart_core_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIVISOR    = 651
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output tx_state_t            tx_state,
  output rx_state_t            rx_state
);

  localparam int DIV_W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int TICK_W     = $clog2(OVERSAMPLE);
  localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam logic [DIV_W-1:0]  DIV_LAST     = DIV_W'(DIVISOR - 1);
  localparam logic [TICK_W-1:0] TICK_LAST    = TICK_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        POS_LAST     = 4'(FRAME_BITS - 1);
  localparam logic [3:0]        POS_DATA_END = 4'(DATA_BITS);

  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [DIV_W-1:0]     tx_div;
  logic [TICK_W-1:0]    tx_tick;
  logic [3:0]           tx_pos;
  logic                 tx_bit_end;

  logic                 smp_done;
  logic [DATA_BITS-1:0] smp_data;
  logic                 smp_perr;
  logic                 smp_ferr;

  assign tx_bit_end = (tx_div == DIV_LAST) && (tx_tick == TICK_LAST);

  // TX FSM: tx_pos walks the frame bit positions, start bit = 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_div   <= '0;
      tx_tick  <= '0;
      tx_pos   <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid && tx_ready) begin
        tx_shift <= tx_data;
        tx_par   <= parity_bit(8'(tx_data), PARITY);
        tx_div   <= '0;
        tx_tick  <= '0;
        tx_pos   <= '0;
        tx       <= 1'b0;
        tx_ready <= 1'b0;
        tx_state <= TX_START;
      end
    end else begin
      if (tx_bit_end) begin
        tx_div  <= '0;
        tx_tick <= '0;
      end else if (tx_div == DIV_LAST) begin
        tx_div  <= '0;
        tx_tick <= tx_tick + 1'b1;
      end else begin
        tx_div <= tx_div + 1'b1;
      end
      if (tx_bit_end) begin
        if (tx_pos == POS_LAST) begin
          tx_state <= TX_IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
        end else begin
          tx_pos <= tx_pos + 1'b1;
          if (tx_pos < POS_DATA_END) begin
            tx_state <= TX_DATA;
            tx       <= tx_shift[0];
            tx_shift <= tx_shift >> 1;
          end else if ((PARITY != PAR_NONE) && (tx_pos == POS_DATA_END)) begin
            tx_state <= TX_PARITY;
            tx       <= tx_par;
          end else begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
          end
        end
      end
    end
  end

  uart_rx_sampler #(
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY),
    .STOP_BITS  (STOP_BITS),
    .OVERSAMPLE (OVERSAMPLE),
    .DIVISOR    (DIVISOR)
  ) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .done       (smp_done),
    .data       (smp_data),
    .parity_err (smp_perr),
    .frame_err  (smp_ferr),
    .state      (rx_state)
  );

  // RX output holding register. A frame finishing in the same cycle as a
  // consumer handshake is loaded, since the slot is being freed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (rx_valid && rx_ready) begin
        rx_valid      <= 1'b0;
        rx_overrun    <= 1'b0;
        rx_parity_err <= 1'b0;
        rx_frame_err  <= 1'b0;
      end
      if (smp_done) begin
        if (!rx_valid || rx_ready) begin
          rx_valid      <= 1'b1;
          rx_data       <= smp_data;
          rx_parity_err <= smp_perr;
          rx_frame_err  <= smp_ferr;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances (8N1 driven RX, 7E2 loopback,
// 8O1 driven RX) at DIVISOR=4, OVERSAMPLE=16, checked against a frame-level
// reference model.
module tb_uart_core_param;
  import uart_pkg::*;

  localparam int OS       = 16;
  localparam int DIV      = 4;
  localparam int BIT_CLKS = OS * DIV;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // dut_a: 8N1
  logic tx_a, rx_a, tx_valid_a, tx_ready_a, rx_valid_a, rx_ready_a, pe_a, fe_a, ov_a;
  logic [7:0] tx_data_a, rx_data_a;
  tx_state_t txs_a; rx_state_t rxs_a;
  // dut_b: 7E2 loopback
  logic tx_b, tx_valid_b, tx_ready_b, rx_valid_b, rx_ready_b, pe_b, fe_b, ov_b;
  logic [6:0] tx_data_b, rx_data_b;
  tx_state_t txs_b; rx_state_t rxs_b;
  // dut_c: 8O1
  logic tx_c, rx_c, tx_valid_c, tx_ready_c, rx_valid_c, rx_ready_c, pe_c, fe_c, ov_c;
  logic [7:0] tx_data_c, rx_data_c;
  tx_state_t txs_c; rx_state_t rxs_c;

  uart_core_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS), .DIVISOR(DIV)) dut_a (
    .clock(clock), .reset(reset), .rx(rx_a), .tx(tx_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ov_a), .tx_state(txs_a), .rx_state(rxs_a));

  uart_core_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .OVERSAMPLE(OS), .DIVISOR(DIV)) dut_b (
    .clock(clock), .reset(reset), .rx(tx_b), .tx(tx_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_overrun(ov_b), .tx_state(txs_b), .rx_state(rxs_b));

  uart_core_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(OS), .DIVISOR(DIV)) dut_c (
    .clock(clock), .reset(reset), .rx(rx_c), .tx(tx_c), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
    .tx_ready(tx_ready_c), .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(rx_ready_c),
    .rx_parity_err(pe_c), .rx_frame_err(fe_c), .rx_overrun(ov_c), .tx_state(txs_c), .rx_state(rxs_c));

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [9:0] exp_q[$];   // {frame_err, parity_err, data}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic ref_parity(input int data, input int dbits, input int mode);
    int ones;
    ones = $countones(data & ((1 << dbits) - 1));
    if (mode == 1) return ((ones % 2) == 0);  // odd: total ones incl. parity is odd
    return ((ones % 2) == 1);                 // even: total ones incl. parity is even
  endfunction

  task automatic build_frame(input int data, input int dbits, input int pmode, input int sbits,
                             input bit flip, input bit stop_zero,
                             output logic [15:0] bits, output int n);
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < dbits; i++) begin bits[n] = 1'((data >> i) & 1); n++; end
    if (pmode != 0) begin bits[n] = ref_parity(data, dbits, pmode) ^ flip; n++; end
    for (int s = 0; s < sbits; s++) begin bits[n] = !(stop_zero && (s == 0)); n++; end
  endtask

  // ---------------- DUT access helpers ----------------
  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic tx_ready_of(input int sel);
    return (sel == 0) ? tx_ready_a : tx_ready_b;
  endfunction
  function automatic logic rx_valid_of(input int sel);
    case (sel)
      0: return rx_valid_a;
      1: return rx_valid_b;
      default: return rx_valid_c;
    endcase
  endfunction
  function automatic logic ov_of(input int sel);
    case (sel)
      0: return ov_a;
      1: return ov_b;
      default: return ov_c;
    endcase
  endfunction
  function automatic logic [9:0] rx_obs(input int sel);
    case (sel)
      0: return {fe_a, pe_a, rx_data_a};
      1: return {fe_b, pe_b, 1'b0, rx_data_b};
      default: return {fe_c, pe_c, rx_data_c};
    endcase
  endfunction
  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v; else rx_c = v;
  endtask
  task automatic set_rx_ready(input int sel, input logic v);
    case (sel)
      0: rx_ready_a = v;
      1: rx_ready_b = v;
      default: rx_ready_c = v;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Sends one byte on dut_a (sel 0) or dut_b (sel 1), checking every bit at
  // its centre, the busy duration, and that tx_valid is ignored while busy.
  task automatic run_tx(input int sel, input logic [7:0] d);
    logic [15:0] bits;
    int n, low;
    if (sel == 0) build_frame(int'(d), 8, 0, 1, 1'b0, 1'b0, bits, n);
    else          build_frame(int'(d & 8'h7f), 7, 2, 2, 1'b0, 1'b0, bits, n);
    @(negedge clock);
    check("tx_ready_idle", 32'(tx_ready_of(sel)), 32'd1);
    if (sel == 0) begin tx_data_a = d; tx_valid_a = 1'b1; end
    else begin tx_data_b = d[6:0]; tx_valid_b = 1'b1; end
    @(posedge clock); #1;
    low = 0;
    for (int k = 0; k < 2000; k++) begin
      if (tx_ready_of(sel)) break;
      low++;
      if (((k % BIT_CLKS) == BIT_CLKS / 2) && ((k / BIT_CLKS) < n))
        check("tx_bit", 32'(tx_of(sel)), 32'(bits[k / BIT_CLKS]));
      if (sel == 0) begin tx_valid_a = 1'($urandom_range(0, 1)); tx_data_a = 8'($urandom); end
      else begin tx_valid_b = 1'($urandom_range(0, 1)); tx_data_b = 7'($urandom); end
      @(posedge clock); #1;
    end
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    check("tx_busy_clks", 32'(low), 32'(n * BIT_CLKS));
    check("tx_idle_line", 32'(tx_of(sel)), 32'd1);
  endtask

  task automatic drive_frame(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(sel, bits[i]);
      repeat (BIT_CLKS) @(negedge clock);
    end
    set_rx(sel, 1'b1);
  endtask

  // Drives a frame into dut_a (8N1) or dut_c (8O1) and queues the expectation.
  task automatic send_rx(input int sel, input logic [7:0] d, input bit flip, input bit stop_zero);
    logic [15:0] bits;
    int n, pmode;
    logic pe, fe;
    pmode = (sel == 0) ? 0 : 1;
    build_frame(int'(d), 8, pmode, 1, flip, stop_zero, bits, n);
    pe = (pmode != 0) && (bits[9] != ref_parity(int'(d), 8, pmode));
    fe = (bits[n-1] == 1'b0);
    exp_q.push_back({fe, pe, d});
    drive_frame(sel, bits, n);
    repeat ($urandom_range(BIT_CLKS, 2 * BIT_CLKS)) @(negedge clock);
  endtask

  // Waits (bounded) for rx_valid, compares against the queue head, then
  // consumes with a one-cycle rx_ready pulse after a random delay.
  task automatic consume(input int sel);
    logic [9:0] want;
    int waited;
    waited = 0;
    while (!rx_valid_of(sel) && (waited < 1000)) begin @(negedge clock); waited++; end
    if (exp_q.size() > 0) want = exp_q.pop_front();
    else want = 10'h3ff;
    check("rx_valid", 32'(rx_valid_of(sel)), 32'd1);
    check("rx_word", 32'(rx_obs(sel)), 32'(want));
    repeat ($urandom_range(0, 20)) @(negedge clock);
    check("rx_hold", 32'(rx_obs(sel)), 32'(want));
    set_rx_ready(sel, 1'b1);
    @(posedge clock); #1;
    set_rx_ready(sel, 1'b0);
    check("rx_valid_clear", 32'(rx_valid_of(sel)), 32'd0);
    check("rx_flags_clear", 32'({rx_obs(sel) >> 8, ov_of(sel)}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] bits;
    int n;
    logic [7:0] d;
    reset = 1'b0;
    rx_a = 1'b1; rx_c = 1'b1;
    tx_valid_a = 1'b0; tx_valid_b = 1'b0; tx_valid_c = 1'b0;
    tx_data_a = '0; tx_data_b = '0; tx_data_c = '0;
    rx_ready_a = 1'b0; rx_ready_b = 1'b0; rx_ready_c = 1'b0;
    repeat (4) @(negedge clock);
    check("rst_tx", 32'({tx_a, tx_b, tx_c}), 32'h7);
    check("rst_tx_ready", 32'({tx_ready_a, tx_ready_b, tx_ready_c}), 32'h7);
    check("rst_rx_valid", 32'({rx_valid_a, rx_valid_b, rx_valid_c}), 32'h0);
    check("rst_rx_word", 32'({rx_obs(0), ov_a}), 32'h0);
    check("rst_states", 32'({txs_a, rxs_a}), 32'({TX_IDLE, RX_IDLE}));
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // 8N1 transmit: fixed 0xC3, then random bytes
    run_tx(0, 8'hC3);
    for (int i = 0; i < 3; i++) run_tx(0, 8'($urandom));

    // 7E2 loopback: 0x55 (parity bit 0 on the wire), then random
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'h55 : 8'($urandom_range(0, 127));
      exp_q.push_back({3'b000, d[6:0]});
      run_tx(1, d);
      consume(1);
    end

    // 8O1 receive: 0xA5 with parity inverted, then random error mixes
    send_rx(2, 8'hA5, 1'b1, 1'b0);
    consume(2);
    for (int i = 0; i < 6; i++) begin
      send_rx(2, 8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      consume(2);
    end

    // 8N1 receive: stop bit low, then random frames
    send_rx(0, 8'h3C, 1'b0, 1'b1);
    consume(0);
    for (int i = 0; i < 5; i++) begin
      send_rx(0, 8'($urandom), 1'b0, ($urandom_range(0, 3) == 0));
      consume(0);
    end

    // Short low pulse on rx is rejected as a glitch
    @(negedge clock); rx_a = 1'b0;
    repeat (20) @(negedge clock); rx_a = 1'b1;
    repeat (300) @(negedge clock);
    check("glitch_no_valid", 32'(rx_valid_a), 32'd0);
    check("glitch_idle", 32'(rxs_a), 32'(RX_IDLE));

    // Overrun: two frames with rx_ready low keep the first
    build_frame(32'h11, 8, 0, 1, 1'b0, 1'b0, bits, n);
    drive_frame(0, bits, n);
    repeat (BIT_CLKS) @(negedge clock);
    build_frame(32'h22, 8, 0, 1, 1'b0, 1'b0, bits, n);
    drive_frame(0, bits, n);
    repeat (BIT_CLKS) @(negedge clock);
    check("ovr_data", 32'(rx_data_a), 32'h11);
    check("ovr_flag", 32'({rx_valid_a, ov_a}), 32'h3);
    rx_ready_a = 1'b1;
    @(posedge clock); #1;
    rx_ready_a = 1'b0;
    check("ovr_clear", 32'({rx_valid_a, ov_a}), 32'h0);

    // Reset mid-frame on both directions while a word is held
    build_frame(32'h77, 8, 0, 1, 1'b0, 1'b0, bits, n);
    drive_frame(0, bits, n);
    repeat (BIT_CLKS) @(negedge clock);
    check("pre_rst_valid", 32'(rx_valid_a), 32'd1);
    tx_data_a = 8'hF0; tx_valid_a = 1'b1;
    @(negedge clock); tx_valid_a = 1'b0; rx_a = 1'b0;
    repeat (4 * BIT_CLKS) @(negedge clock);
    check("pre_rst_busy", 32'({tx_ready_a, txs_a, rxs_a}), 32'({1'b0, TX_DATA, RX_DATA}));
    reset = 1'b0;
    #1;
    check("mid_rst_tx", 32'({tx_a, tx_ready_a}), 32'h3);
    check("mid_rst_rx", 32'({rx_valid_a, rx_obs(0), ov_a}), 32'h0);
    check("mid_rst_states", 32'({txs_a, rxs_a}), 32'({TX_IDLE, RX_IDLE}));
    rx_a = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    send_rx(0, 8'h5A, 1'b0, 1'b0);
    consume(0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Bound on total run time
  initial begin
    #900000;
    $display("FAIL watchdog: run did not complete by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
